// File: rtl/life_pkg.sv
// Shared constants and types for the Game-of-Life pixel renderer.
// COLOR_GRID exists only when LIFE_GRID_LINES_EN is defined.
package life_pkg;

   localparam int unsigned CELL_SHIFT = 3;
   localparam int unsigned COLS       = 60;
   localparam int unsigned ROWS       = 34;
   localparam int unsigned ADDR_W     = 12;
   localparam int unsigned BUF1_BASE  = 2048;
   localparam int unsigned PIX_W      = 9;
   localparam int unsigned RGB_W      = 16;
   localparam int unsigned CELL_IDX_W = $clog2((COLS > ROWS) ? COLS : ROWS);
   localparam int unsigned ROW_OFS_W  = 11;

   localparam logic [RGB_W-1:0] COLOR_ALIVE = 16'hFFE0;
   localparam logic [RGB_W-1:0] COLOR_DEAD  = 16'h0000;
`ifdef LIFE_GRID_LINES_EN
   localparam logic [RGB_W-1:0] COLOR_GRID  = 16'h2104;
`endif

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } swap_state_e;

   typedef struct packed {
      logic de;
      logic hsync;
      logic vsync;
   } timing_t;

   localparam timing_t TIMING_RST = '{de: 1'b0, hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/sync_delay.sv
// N-stage shift register with a per-bit reset value, used to delay-match
// timing signals to the pixel pipeline.
module sync_delay #(
   parameter int unsigned   W       = 1,
   parameter int unsigned   N       = 1,
   parameter logic [W-1:0]  RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_sr [N];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < int'(N); i++) r_sr[i] <= RST_VAL;
      end else begin
         r_sr[0] <= i_d;
         for (int i = 1; i < int'(N); i++) r_sr[i] <= r_sr[i-1];
      end
   end

   assign o_q = r_sr[N-1];

endmodule

// File: rtl/life_pixel_render.sv
// Game-of-Life pixel renderer: maps LCD pixels to cells in a double-buffered
// cell RAM, emits RGB565 with 2-cycle aligned timing. Optional: LIFE_GRID_LINES_EN.
module life_pixel_render
   import life_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_de,
   input  logic              i_hsync,
   input  logic              i_vsync,
   input  logic [PIX_W-1:0]  i_x,
   input  logic [PIX_W-1:0]  i_y,
   output logic [ADDR_W-1:0] o_ram_addr,
   input  logic              i_ram_data,
   input  logic              i_swap_req,
   output logic              o_swap_ack,
   output logic              o_buf_sel,
   output logic              o_frame_pulse,
   output logic [RGB_W-1:0]  o_rgb,
   output logic              o_de,
   output logic              o_hsync,
   output logic              o_vsync
);

   timing_t                 w_tim_in, w_tim_s0, w_tim_s1;
   logic [CELL_IDX_W-1:0]   w_x_cell, w_y_cell;
   logic [ROW_OFS_W-1:0]    w_cell_ofs;
   logic [ADDR_W-1:0]       w_base, w_addr;
   logic [ADDR_W-1:0]       r_ram_addr;
   logic [RGB_W-1:0]        w_pix, r_rgb;
   logic                    w_frame_start, w_swap;
   logic                    r_vsync_prev, r_frame_pulse, r_swap_ack, r_buf_sel;
   swap_state_e             r_state, w_state_nxt;

   // Stage 0: cell address from the current pixel position
   assign w_tim_in   = '{de: i_de, hsync: i_hsync, vsync: i_vsync};
   assign w_x_cell   = CELL_IDX_W'(i_x >> CELL_SHIFT);
   assign w_y_cell   = CELL_IDX_W'(i_y >> CELL_SHIFT);
   assign w_cell_ofs = ROW_OFS_W'(w_y_cell) * ROW_OFS_W'(COLS) + ROW_OFS_W'(w_x_cell);
   assign w_base     = r_buf_sel ? ADDR_W'(BUF1_BASE) : '0;
   assign w_addr     = w_base + ADDR_W'(w_cell_ofs);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_ram_addr <= '0;
      else       r_ram_addr <= i_de ? w_addr : w_base;
   end

   sync_delay #(.W($bits(timing_t)), .N(1), .RST_VAL(TIMING_RST)) u_tim_s0 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (w_tim_in),
      .o_q   (w_tim_s0)
   );

   sync_delay #(.W($bits(timing_t)), .N(1), .RST_VAL(TIMING_RST)) u_tim_s1 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (w_tim_s0),
      .o_q   (w_tim_s1)
   );

   // Stage 1: colour from the cell bit returned for the stage-0 address
`ifdef LIFE_GRID_LINES_EN
   logic w_grid_in, w_grid_s0;

   assign w_grid_in = (i_x[CELL_SHIFT-1:0] == '0) || (i_y[CELL_SHIFT-1:0] == '0);

   sync_delay #(.W(1), .N(1), .RST_VAL(1'b0)) u_grid_s0 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (w_grid_in),
      .o_q   (w_grid_s0)
   );

   always_comb begin
      w_pix = '0;
      if (w_tim_s0.de) w_pix = w_grid_s0 ? COLOR_GRID : (i_ram_data ? COLOR_ALIVE : COLOR_DEAD);
   end
`else
   logic w_unused_lsb;
   assign w_unused_lsb = ^{i_x[CELL_SHIFT-1:0], i_y[CELL_SHIFT-1:0]};

   always_comb begin
      w_pix = '0;
      if (w_tim_s0.de) w_pix = i_ram_data ? COLOR_ALIVE : COLOR_DEAD;
   end
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_rgb <= '0;
      else       r_rgb <= w_pix;
   end

   // Frame start is the vsync falling edge; swaps happen only there
   assign w_frame_start = !i_vsync && r_vsync_prev;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_ARMED;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_swap      = 1'b0;
      case (r_state)
         ST_ARMED: begin
            if (w_frame_start && i_swap_req) begin
               w_swap      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (!i_swap_req) w_state_nxt = ST_ARMED;
         end
         default: w_state_nxt = ST_ARMED;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_vsync_prev  <= 1'b1;
         r_frame_pulse <= 1'b0;
         r_swap_ack    <= 1'b0;
         r_buf_sel     <= 1'b0;
      end else begin
         r_vsync_prev  <= i_vsync;
         r_frame_pulse <= w_frame_start;
         r_swap_ack    <= w_swap;
         if (w_swap) r_buf_sel <= ~r_buf_sel;
      end
   end

   assign o_ram_addr    = r_ram_addr;
   assign o_rgb         = r_rgb;
   assign o_de          = w_tim_s1.de;
   assign o_hsync       = w_tim_s1.hsync;
   assign o_vsync       = w_tim_s1.vsync;
   assign o_frame_pulse = r_frame_pulse;
   assign o_swap_ack    = r_swap_ack;
   assign o_buf_sel     = r_buf_sel;

endmodule

// File: tb/tb_life_pixel_render.sv
// Directed bench for life_pixel_render with a small cell-RAM model.
// Grid expectations follow LIFE_GRID_LINES_EN.
module tb_life_pixel_render;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_de, i_hsync, i_vsync;
   logic [8:0]  i_x, i_y;
   logic [11:0] o_ram_addr;
   logic        i_ram_data;
   logic        i_swap_req;
   logic        o_swap_ack, o_buf_sel, o_frame_pulse;
   logic [15:0] o_rgb;
   logic        o_de, o_hsync, o_vsync;

   logic        cell_mem [4096];
   int          n_cmp = 0;
   int          n_err = 0;
   logic        m_buf;
   logic [15:0] p_rgb;
   logic        p_de, p_hs, p_vs;

   life_pixel_render dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_de          (i_de),
      .i_hsync       (i_hsync),
      .i_vsync       (i_vsync),
      .i_x           (i_x),
      .i_y           (i_y),
      .o_ram_addr    (o_ram_addr),
      .i_ram_data    (i_ram_data),
      .i_swap_req    (i_swap_req),
      .o_swap_ack    (o_swap_ack),
      .o_buf_sel     (o_buf_sel),
      .o_frame_pulse (o_frame_pulse),
      .o_rgb         (o_rgb),
      .o_de          (o_de),
      .o_hsync       (o_hsync),
      .o_vsync       (o_vsync)
   );

   always #5 i_clk = ~i_clk;

   // Registered address -> data valid one cycle later
   assign i_ram_data = cell_mem[o_ram_addr];

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model_rgb(input logic de, input logic [8:0] x, input logic [8:0] y);
      int addr;
      if (!de) return 16'h0000;
`ifdef LIFE_GRID_LINES_EN
      if (x[2:0] == 3'd0 || y[2:0] == 3'd0) return 16'h2104;
`endif
      addr = (m_buf ? 2048 : 0) + int'(y / 9'd8) * 60 + int'(x / 9'd8);
      return cell_mem[addr] ? 16'hFFE0 : 16'h0000;
   endfunction

   task automatic reset_prev();
      p_rgb = 16'h0000;
      p_de  = 1'b0;
      p_hs  = 1'b1;
      p_vs  = 1'b1;
   endtask

   // Drive one pixel; outputs sampled after the edge reflect the previous drive
   task automatic drive_cycle(input logic de, input logic hs, input logic vs,
                              input logic [8:0] x, input logic [8:0] y);
      logic [15:0] exp_now;
      i_de = de; i_hsync = hs; i_vsync = vs; i_x = x; i_y = y;
      exp_now = model_rgb(de, x, y);
      @(posedge i_clk); #1;
      check_eq("rgb",   o_rgb,          p_rgb);
      check_eq("de",    16'(o_de),      16'(p_de));
      check_eq("hsync", 16'(o_hsync),   16'(p_hs));
      check_eq("vsync", 16'(o_vsync),   16'(p_vs));
      p_rgb = exp_now; p_de = de; p_hs = hs; p_vs = vs;
   endtask

   task automatic run_frame(input logic exp_swap);
      drive_cycle(1'b0, 1'b1, 1'b0, 9'd0, 9'd0);
      if (exp_swap) m_buf = ~m_buf;
      check_eq("frame_pulse", 16'(o_frame_pulse), 16'd1);
      check_eq("swap_ack",    16'(o_swap_ack),    16'(exp_swap));
      check_eq("buf_sel",     16'(o_buf_sel),     16'(m_buf));
      drive_cycle(1'b0, 1'b1, 1'b0, 9'd0, 9'd0);
      check_eq("pulse_width", 16'(o_frame_pulse), 16'd0);
      check_eq("ack_width",   16'(o_swap_ack),    16'd0);
      drive_cycle(1'b0, 1'b1, 1'b1, 9'd0, 9'd0);
      for (int x = 0; x < 4; x++) drive_cycle(1'b1, 1'b1, 1'b1, 9'(x * 8), 9'd12);
      drive_cycle(1'b0, 1'b0, 1'b1, 9'd0, 9'd0);
      check_eq("buf_sel_active", 16'(o_buf_sel), 16'(m_buf));
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) cell_mem[i] = 1'b0;
      cell_mem[0]         = 1'b1;
      cell_mem[61]        = 1'b1;
      cell_mem[2048 + 61] = 1'b1;
      cell_mem[2048 + 1]  = 1'b1;
      m_buf = 1'b0;
      reset_prev();
      i_rst = 1'b1; i_de = 1'b0; i_hsync = 1'b1; i_vsync = 1'b1;
      i_x = '0; i_y = '0; i_swap_req = 1'b0;

      repeat (2) @(posedge i_clk);
      #1;
      check_eq("rst_rgb",    o_rgb,                16'h0000);
      check_eq("rst_de",     16'(o_de),            16'd0);
      check_eq("rst_hsync",  16'(o_hsync),         16'd1);
      check_eq("rst_vsync",  16'(o_vsync),         16'd1);
      check_eq("rst_addr",   16'(o_ram_addr),      16'd0);
      check_eq("rst_buf",    16'(o_buf_sel),       16'd0);
      check_eq("rst_ack",    16'(o_swap_ack),      16'd0);
      check_eq("rst_pulse",  16'(o_frame_pulse),   16'd0);
      i_rst = 1'b0;

      // Row 0: cell (0,0) live for x=0..7, dead at x=8
      for (int x = 0; x <= 9; x++) drive_cycle(1'b1, 1'b1, 1'b1, 9'(x), 9'd0);
      drive_cycle(1'b0, 1'b1, 1'b1, 9'd0, 9'd0);

      drive_cycle(1'b1, 1'b1, 1'b1, 9'd13, 9'd20);
      check_eq("addr_13_20", 16'(o_ram_addr), 16'd121);
      drive_cycle(1'b1, 1'b1, 1'b1, 9'd479, 9'd271);
      check_eq("addr_last_b0", 16'(o_ram_addr), 16'd2039);
      drive_cycle(1'b0, 1'b1, 1'b1, 9'd479, 9'd271);
      check_eq("addr_idle_b0", 16'(o_ram_addr), 16'd0);

      // Swap handshake
      run_frame(1'b0);
      i_swap_req = 1'b1;
      drive_cycle(1'b0, 1'b1, 1'b1, 9'd0, 9'd0);
      run_frame(1'b1);
      run_frame(1'b0);
      run_frame(1'b0);
      i_swap_req = 1'b0;
      drive_cycle(1'b0, 1'b1, 1'b1, 9'd0, 9'd0);
      i_swap_req = 1'b1;
      drive_cycle(1'b0, 1'b1, 1'b1, 9'd0, 9'd0);
      run_frame(1'b1);
      i_swap_req = 1'b0;
      drive_cycle(1'b0, 1'b1, 1'b1, 9'd0, 9'd0);
      i_swap_req = 1'b1;
      drive_cycle(1'b0, 1'b1, 1'b1, 9'd0, 9'd0);
      i_swap_req = 1'b0;
      drive_cycle(1'b0, 1'b1, 1'b1, 9'd0, 9'd0);
      run_frame(1'b0);
      i_swap_req = 1'b1;
      run_frame(1'b1);
      i_swap_req = 1'b0;
      check_eq("buf_after_swaps", 16'(o_buf_sel), 16'd1);

      drive_cycle(1'b1, 1'b1, 1'b1, 9'd479, 9'd271);
      check_eq("addr_last_b1", 16'(o_ram_addr), 16'd4087);
      drive_cycle(1'b0, 1'b1, 1'b1, 9'd0, 9'd0);
      check_eq("addr_idle_b1", 16'(o_ram_addr), 16'd2048);

      // Cell (1,1) live: grid line at x=8, interior at x=9
      drive_cycle(1'b1, 1'b1, 1'b1, 9'd8, 9'd9);
      drive_cycle(1'b1, 1'b1, 1'b1, 9'd9, 9'd9);
`ifdef LIFE_GRID_LINES_EN
      check_eq("grid_8_9", o_rgb, 16'h2104);
`else
      check_eq("grid_8_9", o_rgb, 16'hFFE0);
`endif
      drive_cycle(1'b0, 1'b1, 1'b1, 9'd0, 9'd0);
      check_eq("cell_9_9", o_rgb, 16'hFFE0);

      // Random timing stream
      for (int n = 0; n < 200; n++) begin
         drive_cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                     9'($urandom_range(479)), 9'($urandom_range(271)));
      end
      drive_cycle(1'b0, 1'b1, 1'b1, 9'd0, 9'd0);
      check_eq("buf_after_random", 16'(o_buf_sel), 16'd1);

      // Reset mid-line with a pending request
      i_swap_req = 1'b1;
      drive_cycle(1'b1, 1'b1, 1'b1, 9'd0, 9'd0);
      drive_cycle(1'b1, 1'b1, 1'b1, 9'd1, 9'd0);
      check_eq("pre_rst_de", 16'(o_de), 16'd1);
      i_rst = 1'b1;
      #1;
      check_eq("mid_rst_rgb",   o_rgb,              16'h0000);
      check_eq("mid_rst_de",    16'(o_de),          16'd0);
      check_eq("mid_rst_hsync", 16'(o_hsync),       16'd1);
      check_eq("mid_rst_vsync", 16'(o_vsync),       16'd1);
      check_eq("mid_rst_addr",  16'(o_ram_addr),    16'd0);
      check_eq("mid_rst_buf",   16'(o_buf_sel),     16'd0);
      i_swap_req = 1'b0;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      m_buf = 1'b0;
      reset_prev();
      drive_cycle(1'b1, 1'b1, 1'b1, 9'd2, 9'd3);
      drive_cycle(1'b1, 1'b1, 1'b1, 9'd8, 9'd3);
      check_eq("post_rst_de", 16'(o_de), 16'd1);
      drive_cycle(1'b0, 1'b1, 1'b1, 9'd0, 9'd0);
      drive_cycle(1'b0, 1'b1, 1'b1, 9'd0, 9'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/life_pixel_render.md
Name: life_pixel_render

Overview:
- Sits directly downstream of the LCD timing generator and consumes its de/hsync/vsync/x/y stream.
- Maps each active pixel to a Game-of-Life cell (8x8 px per cell, 60x34 grid on a 480x272 panel) and reads the cell bit from a double-buffered cell RAM.
- Outputs RGB565 pixels with timing signals delay-matched to the data.
- Swaps the displayed buffer only at frame start, under a req/ack handshake with the life engine.

Parameters:
- CELL_SHIFT, 3: log2 of cell size in pixels.
- COLS, 60: cells per row.
- ROWS, 34: cells per column.
- ADDR_W, 12: cell RAM address width. Buffer 1 base address is 2048.
- COLOR_ALIVE, 16'hFFE0: RGB565 colour for a live cell.
- COLOR_DEAD, 16'h0000: RGB565 colour for a dead cell.
- COLOR_GRID, 16'h2104: grid-line colour (optional feature only).

Ports:
- i_clk  in  1  pixel clock
- i_rst  in  1  reset, asynchronous, active-high
- i_de  in  1  data enable from the timing generator
- i_hsync  in  1  active-low hsync
- i_vsync  in  1  active-low vsync
- i_x  in  9  active-area pixel X
- i_y  in  9  active-area pixel Y
- o_ram_addr  out  ADDR_W  cell RAM read address
- i_ram_data  in  1  cell bit; valid 1 cycle after the address is presented
- i_swap_req  in  1  engine request to display the other buffer (level)
- o_swap_ack  out  1  one-cycle pulse: swap performed
- o_buf_sel  out  1  buffer currently displayed
- o_frame_pulse  out  1  one-cycle pulse at frame start
- o_rgb  out  16  RGB565 pixel
- o_de  out  1  aligned data enable
- o_hsync  out  1  aligned hsync
- o_vsync  out  1  aligned vsync

Behaviour:
- Reset values:
  - o_rgb=0, o_de=0, o_hsync=1, o_vsync=1.
  - o_ram_addr=0, o_buf_sel=0, o_swap_ack=0, o_frame_pulse=0.
  - Internal vsync_prev=1, armed=1.
- Reset mid-frame aborts any pending swap. Output resumes correctly from the next valid input.
- Stage 0 (registered):
  - o_ram_addr = o_buf_sel*2048 + (i_y>>CELL_SHIFT)*COLS + (i_x>>CELL_SHIFT).
  - Cell indices are 6-bit; the product is unsigned and 11 bits wide.
  - When i_de=0, the address is held at the buffer base.
- Stage 1 (registered): o_rgb = delayed de ? (i_ram_data ? COLOR_ALIVE : COLOR_DEAD) : 0.
- Latency: o_rgb, o_de, o_hsync and o_vsync all equal the corresponding inputs delayed by exactly 2 cycles. No pixel skew.
- Frame start: the cycle where i_vsync is 0 and vsync_prev is 1 (falling edge). o_frame_pulse goes high the following cycle for 1 cycle, every frame.
- Swap handshake (states IDLE / ARMED):
  - If armed and i_swap_req=1 at a frame-start edge: toggle o_buf_sel, pulse o_swap_ack for 1 cycle (same cycle as o_frame_pulse), clear armed.
  - armed is set again once i_swap_req is sampled 0.
  - A request raised mid-frame waits for the next edge. A request raised in the same cycle as the edge is honoured.
  - A request held high across several frames produces exactly one swap.
  - A request dropped before the edge produces no swap.
- o_buf_sel never changes during active video.
- Out-of-grid pixels cannot occur at defaults: x<=479 maps to cell 59, y<=271 maps to cell 33.

Optional Feature:
- Macro LIFE_GRID_LINES_EN.
- Defined: pixels with x[2:0]==0 or y[2:0]==0 output COLOR_GRID whatever the cell state. The x/y low bits are pipelined to stay aligned with stage 1. Latency stays 2.
- Undefined: no grid; that logic is absent.

Decomposition:
- Package life_pkg: CELL_SHIFT, COLS, ROWS, BUF1_BASE=2048, RGB565 colour constants, cell-index width.
- One natural sub-module, sync_delay: a parameterised N-stage shift register with a per-bit reset value, used for de, hsync, vsync and the grid bits.

Test Plan:
- Assert i_rst mid-line while o_de=1 -> all outputs at reset values immediately. After release, the first active pixel appears 2 cycles after i_de.
- Cell RAM model with buffer 0, cell (0,0)=1; drive x=0..8, y=0 with de=1 -> o_rgb=FFE0 for 8 pixels, then 0000, each 2 cycles later. x=13, y=20 -> o_ram_addr=121.
- Last pixel: x=479, y=271 -> address 2039 with buf_sel=0, 4087 with buf_sel=1.
- Raise i_swap_req mid-frame and hold it 3 frames -> buf_sel toggles once at the next vsync falling edge; o_swap_ack is a 1-cycle pulse coincident with o_frame_pulse. Drop then re-raise the request -> second swap at the following frame.
- Random timing stream -> o_hsync, o_vsync and o_de each equal their input delayed exactly 2 cycles, every cycle.
- With LIFE_GRID_LINES_EN, cell (1,1)=1: x=8, y=9 -> 2104; x=9, y=9 -> FFE0.
